// File: rtl/trace_pkg_v12.sv
// trace_pkg_v12: shared trace record geometry, FSM states and size decode.
package trace_pkg_v12;
    localparam int TRACE_REC_W   = 512;
    localparam int TRACE_BEAT_W  = 64;
    localparam int REC_BYTES_V11 = 48;
    localparam int REC_BYTES_V12 = 64;

    typedef enum logic {IDLE, SEND} state_t;

    // Only a v1.1-sized record is short; everything else goes out as a full 512-bit word.
    function automatic logic [3:0] beats_for_size(input logic [6:0] size);
        return (size == 7'(REC_BYTES_V11)) ? 4'd6 : 4'd8;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or above ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] c;

    // Walk candidates from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = IDX_W'((int'(ptr) + i) % N);
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/trace_rr_mux.sv
// trace_rr_mux: round-robin merge of per-core 512-bit trace records into a
// little-endian 64-bit beat stream tagged with the source core.
module trace_rr_mux
    import trace_pkg_v12::*;
#(
    parameter int NUM_CORES = 4,
    parameter int SRC_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CORES-1:0]   in_valid,
    output logic [NUM_CORES-1:0]   in_ready,
    input  logic [NUM_CORES*512-1:0] in_data,
    input  logic [NUM_CORES*7-1:0] in_size,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic                   out_last,
    output logic [SRC_W-1:0]       out_src,
    output logic [31:0]            rec_count,
    output logic [31:0]            size_err_count
);
    state_t                  state, state_n;
    logic [SRC_W-1:0]        rr_ptr, gidx;
    logic [NUM_CORES-1:0]    grant;
    logic                    any_req, accept, beat_fire, last_beat, size_bad;
    logic [2:0]              beat_idx;
    logic [3:0]              beat_cnt;
    logic [6:0]              sel_size;
    logic [TRACE_REC_W-1:0]  hold_reg;

    rr_arbiter #(.N(NUM_CORES), .IDX_W(SRC_W)) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any_req)
    );

    assign sel_size  = in_size[7*gidx +: 7];
    assign size_bad  = (sel_size != 7'(REC_BYTES_V11)) && (sel_size != 7'(REC_BYTES_V12));
    assign accept    = (state == IDLE) && any_req;
    assign last_beat = ({1'b0, beat_idx} == beat_cnt - 4'd1);
    assign beat_fire = (state == SEND) && out_ready;

    assign in_ready  = (state == IDLE) ? grant : '0;
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && last_beat;
    assign out_data  = (state == SEND) ? hold_reg[TRACE_BEAT_W*beat_idx +: TRACE_BEAT_W] : '0;

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (any_req ? SEND : IDLE)
                                  : ((out_ready && last_beat) ? IDLE : SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            beat_idx       <= '0;
            beat_cnt       <= 4'd8;
            hold_reg       <= '0;
            out_src        <= '0;
            rec_count      <= '0;
            size_err_count <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                hold_reg <= in_data[TRACE_REC_W*gidx +: TRACE_REC_W];
                out_src  <= gidx;
                beat_cnt <= beats_for_size(sel_size);
                beat_idx <= '0;
                rr_ptr   <= (gidx == SRC_W'(NUM_CORES - 1)) ? '0 : gidx + 1'b1;
                if (size_bad && size_err_count != 32'hFFFF_FFFF)
                    size_err_count <= size_err_count + 32'd1;
            end
            // Beat index only moves on a handshake, so stalls hold data/last/src.
            if (beat_fire) begin
                if (last_beat)
                    rec_count <= rec_count + 32'd1;
                else
                    beat_idx <= beat_idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_trace_rr_mux.sv
// tb_trace_rr_mux: directed scenarios for trace_rr_mux with hand-computed expectations.
module tb_trace_rr_mux;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     in_valid, in_ready;
    logic [N*512-1:0] in_data;
    logic [N*7-1:0]   in_size;
    logic             out_valid, out_ready, out_last;
    logic [63:0]      out_data;
    logic [1:0]       out_src;
    logic [31:0]      rec_count, size_err_count;

    int n_cmp = 0;
    int n_bad = 0;

    trace_rr_mux #(.NUM_CORES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_size(in_size),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_src(out_src),
        .rec_count(rec_count), .size_err_count(size_err_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_rec(input logic [63:0] base);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = base + 64'(k);
        return r;
    endfunction

    task automatic load(input int c, input logic [63:0] base, input logic [6:0] sz);
        in_data[512*c +: 512] = mk_rec(base);
        in_size[7*c +: 7]     = sz;
        in_valid[c]           = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b1; in_data = '0; in_size = '0;
        repeat (2) tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        n_cmp++; if (rec_count !== 32'd0) begin n_bad++; $display("FAIL reset_rec_count: got %0d want 0", rec_count); end
        n_cmp++; if (size_err_count !== 32'd0) begin n_bad++; $display("FAIL reset_size_err: got %0d want 0", size_err_count); end
        rst_n = 1'b1;
        tick;
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_no_valid_ready: got %b want 0000", in_ready); end
    endtask

    task automatic test_single_v12;
        load(0, 64'h1000, 7'd64);
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL single_in_ready: got %b want 0001", in_ready); end
        tick;
        in_valid = '0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid beat %0d: got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== 64'h1000 + 64'(k)) begin n_bad++; $display("FAIL single_data beat %0d: got %h want %h", k, out_data, 64'h1000 + 64'(k)); end
            n_cmp++; if (out_last !== (k == 7)) begin n_bad++; $display("FAIL single_last beat %0d: got %b want %b", k, out_last, k == 7); end
            n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL single_src beat %0d: got %0d want 0", k, out_src); end
            n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_in_send beat %0d: got %b want 0000", k, in_ready); end
            tick;
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_idle_after: got %b want 0", out_valid); end
        n_cmp++; if (rec_count !== 32'd1) begin n_bad++; $display("FAIL single_rec_count: got %0d want 1", rec_count); end
    endtask

    task automatic test_v11_core2;
        load(2, 64'h2000, 7'd48);
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL v11_in_ready: got %b want 0100", in_ready); end
        tick;
        in_valid = '0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (out_data !== 64'h2000 + 64'(k)) begin n_bad++; $display("FAIL v11_data beat %0d: got %h want %h", k, out_data, 64'h2000 + 64'(k)); end
            n_cmp++; if (out_last !== (k == 5)) begin n_bad++; $display("FAIL v11_last beat %0d: got %b want %b", k, out_last, k == 5); end
            n_cmp++; if (out_src !== 2'd2) begin n_bad++; $display("FAIL v11_src beat %0d: got %0d want 2", k, out_src); end
            tick;
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL v11_no_beat6: got %b want 0", out_valid); end
        n_cmp++; if (rec_count !== 32'd2) begin n_bad++; $display("FAIL v11_rec_count: got %0d want 2", rec_count); end
        n_cmp++; if (size_err_count !== 32'd0) begin n_bad++; $display("FAIL v11_size_err: got %0d want 0", size_err_count); end
    endtask

    task automatic test_round_robin;
        int gcnt[N];
        int exp_c;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0;
            load(i, 64'hA000 + 64'(i) * 64'h100, 7'd64);
        end
        #1;
        for (int r = 0; r < 8; r++) begin
            exp_c = r % N;
            n_cmp++; if (in_ready !== 4'(1 << exp_c)) begin n_bad++; $display("FAIL rr_grant rec %0d: got %b want %b", r, in_ready, 4'(1 << exp_c)); end
            for (int i = 0; i < N; i++) if (in_ready[i]) gcnt[i]++;
            tick;
            for (int k = 0; k < 8; k++) begin
                n_cmp++; if (out_src !== 2'(exp_c)) begin n_bad++; $display("FAIL rr_src rec %0d beat %0d: got %0d want %0d", r, k, out_src, exp_c); end
                n_cmp++; if (out_data !== 64'hA000 + 64'(exp_c) * 64'h100 + 64'(k)) begin n_bad++; $display("FAIL rr_data rec %0d beat %0d: got %h", r, k, out_data); end
                tick;
            end
        end
        in_valid = '0;
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (gcnt[i] !== 2) begin n_bad++; $display("FAIL rr_grants core %0d: got %0d want 2", i, gcnt[i]); end
        end
        n_cmp++; if (rec_count !== 32'd8) begin n_bad++; $display("FAIL rr_rec_count: got %0d want 8", rec_count); end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat = 4'b1001;
        int exp_k = 0;
        int cyc = 0;
        load(3, 64'h3000, 7'd64);
        #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_in_ready: got %b want 1000", in_ready); end
        tick;
        in_valid = '0;
        while (exp_k < 8 && cyc < 40) begin
            out_ready = pat[cyc % 4];
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid cyc %0d: got %b want 1", cyc, out_valid); end
            n_cmp++; if (out_data !== 64'h3000 + 64'(exp_k)) begin n_bad++; $display("FAIL bp_data cyc %0d: got %h want %h", cyc, out_data, 64'h3000 + 64'(exp_k)); end
            n_cmp++; if (out_last !== (exp_k == 7)) begin n_bad++; $display("FAIL bp_last cyc %0d: got %b want %b", cyc, out_last, exp_k == 7); end
            n_cmp++; if (out_src !== 2'd3) begin n_bad++; $display("FAIL bp_src cyc %0d: got %0d want 3", cyc, out_src); end
            tick;
            if (out_ready) exp_k++;
            cyc++;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (exp_k !== 8) begin n_bad++; $display("FAIL bp_beats: got %0d want 8", exp_k); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_after: got %b want 0", out_valid); end
        n_cmp++; if (rec_count !== 32'd9) begin n_bad++; $display("FAIL bp_rec_count: got %0d want 9", rec_count); end
    endtask

    task automatic test_size_err;
        load(1, 64'h5000, 7'd32);
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL serr_in_ready: got %b want 0010", in_ready); end
        tick;
        in_valid = '0;
        n_cmp++; if (size_err_count !== 32'd1) begin n_bad++; $display("FAIL serr_count: got %0d want 1", size_err_count); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (out_data !== 64'h5000 + 64'(k)) begin n_bad++; $display("FAIL serr_data beat %0d: got %h want %h", k, out_data, 64'h5000 + 64'(k)); end
            n_cmp++; if (out_last !== (k == 7)) begin n_bad++; $display("FAIL serr_last beat %0d: got %b want %b", k, out_last, k == 7); end
            tick;
        end
        load(1, 64'h6000, 7'd64);
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL serr2_in_ready: got %b want 0010", in_ready); end
        tick;
        in_valid = '0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (out_data !== 64'h6000 + 64'(k)) begin n_bad++; $display("FAIL serr2_data beat %0d: got %h want %h", k, out_data, 64'h6000 + 64'(k)); end
            tick;
        end
        n_cmp++; if (size_err_count !== 32'd1) begin n_bad++; $display("FAIL serr2_count: got %0d want 1", size_err_count); end
        n_cmp++; if (rec_count !== 32'd11) begin n_bad++; $display("FAIL serr2_rec_count: got %0d want 11", rec_count); end
    endtask

    task automatic test_reset_mid;
        load(0, 64'h7000, 7'd64);
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 0001", in_ready); end
        tick;
        in_valid = '0;
        repeat (3) tick;
        n_cmp++; if (out_data !== 64'h7003) begin n_bad++; $display("FAIL rmid_beat3: got %h want 7003", out_data); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_async_valid: got %b want 0", out_valid); end
        tick;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_after: got %b want 0", out_valid); end
        n_cmp++; if (rec_count !== 32'd0) begin n_bad++; $display("FAIL rmid_rec_count: got %0d want 0", rec_count); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rmid_in_ready_idle: got %b want 0000", in_ready); end
        load(2, 64'h8000, 7'd64);
        load(0, 64'h9000, 7'd64);
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr0_grant: got %b want 0001", in_ready); end
        tick;
        in_valid = '0;
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL rmid_src: got %0d want 0", out_src); end
        n_cmp++; if (out_data !== 64'h9000) begin n_bad++; $display("FAIL rmid_data: got %h want 9000", out_data); end
    endtask

    initial begin
        test_reset;
        test_single_v12;
        test_v11_core2;
        test_round_robin;
        test_backpressure;
        test_size_err;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trace_rr_mux.md
Name: trace_rr_mux

Overview:
- Merges trace-record streams from NUM_CORES instrumentation shells into one serialized 64-bit trace stream for the host DMA/PCIe path.
- Round-robin arbitration between cores.
- Each granted record (48 B v1.1 or 64 B v1.2, presented as 512-bit words) is latched, then emitted as 6 or 8 little-endian 64-bit beats with a last marker and source core tag.
- Sits between the per-core shell trace ports and the host trace sink.

Parameters:
- NUM_CORES, 4, number of upstream trace ports (1..16).
- SRC_W, (NUM_CORES>1 ? $clog2(NUM_CORES) : 1), width of the source tag (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CORES  per-core trace record valid.
- in_ready  out  NUM_CORES  per-core accept; one-hot or zero.
- in_data  in  NUM_CORES*512  per-core record; core i occupies bits [512*i+511:512*i].
- in_size  in  NUM_CORES*7  per-core record size in bytes; core i occupies bits [7*i+6:7*i].
- out_valid  out  1  beat valid.
- out_ready  in  1  beat accept.
- out_data  out  64  beat payload.
- out_last  out  1  final beat of a record.
- out_src  out  SRC_W  core index of the record being sent.
- rec_count  out  32  records fully emitted.
- size_err_count  out  32  records accepted with in_size not 48 and not 64.

Behaviour:
- States: IDLE, SEND. Reset state is IDLE.
- Reset values: out_valid=0, out_last=0, out_data=0, out_src=0, in_ready=0, rec_count=0, size_err_count=0, rr_ptr=0, beat_idx=0. Reset mid-record drops the held record with no partial completion.
- IDLE:
  - Pick the first core g with in_valid[g]=1, searching from rr_ptr upward modulo NUM_CORES.
  - Drive in_ready[g]=1 combinationally in the same cycle; in_ready is 0 for all other cores.
  - On that clock edge: latch in_data[g] into hold_reg, latch g into out_src, set beat_cnt (6 if in_size[g]==48, else 8), beat_idx=0, rr_ptr=(g+1) mod NUM_CORES, go to SEND.
  - If in_size[g] is neither 48 nor 64, increment size_err_count (saturating at 2^32-1); the record is still sent as 8 beats.
  - No in_valid: stay in IDLE, in_ready=0.
- SEND:
  - out_valid=1, out_data=hold_reg[64*beat_idx +: 64], out_last=(beat_idx==beat_cnt-1). in_ready=0 throughout.
  - On out_valid&&out_ready with not last: beat_idx+1.
  - On the last-beat handshake: rec_count+1 (wraps at 2^32), go to IDLE.
  - out_ready=0: hold all outputs stable, with no change to data/last/src.
- Timing:
  - Accept at cycle t gives the first beat valid at t+1.
  - There is one IDLE cycle between records, so peak throughput is 8 beats per 9 cycles (v1.2) and 6 per 7 (v1.1).
- Fairness: a core that keeps in_valid high is granted at most once per NUM_CORES grants while others request. rr_ptr advances only on a grant.
- Upstream valid must stay asserted until in_ready; the mux never drops records.
- Each count saturates or wraps as stated; counters update on their handshake cycle only.

Decomposition:
- Add to trace_pkg_v12:
  - TRACE_REC_W=512 and TRACE_BEAT_W=64.
  - REC_BYTES_V11=48 and REC_BYTES_V12=64.
  - A function beats_for_size(size) returning 6 or 8.
- Natural sub-module: rr_arbiter (NUM_CORES request vector plus pointer in, one-hot grant and index out, purely combinational priority rotate). The FSM and serializer stay in trace_rr_mux.

Test Plan:
- Single core 0 with in_size=64, in_data word k = 64'h1000+k, out_ready=1 -> in_ready[0] pulses 1 cycle; 8 beats 0x1000..0x1007 in consecutive cycles; out_last on beat 7; out_src=0; rec_count=1.
- Core 2 with in_size=48 -> exactly 6 beats, out_last on beat 5; bytes 48..63 never emitted; rec_count increments once.
- All 4 cores continuously valid, 8 records -> grant order 0,1,2,3,0,1,2,3 by out_src; no in_ready overlap; each core granted exactly 2 times.
- out_ready toggled 1,0,0,1 during SEND -> beat index and out_data held while out_ready=0; no beats lost or duplicated; 8 beats total.
- in_size=32 on core 1 -> size_err_count=1; 8 beats emitted; a following size-64 record leaves size_err_count unchanged.
- rst_n asserted on beat 3 of a record, then released with no valid -> out_valid=0 next cycle, state IDLE, rec_count=0; the next record from core 0 is granted first (rr_ptr=0).
